// File: rtl/priority_queue_driver.sv
// Initiator for a priority_queue request port: arbitrates push/pop streams, mirrors occupancy and
// buffers pop results in a response FIFO. Define PQ_DRIVER_CHECK_EN to cross-check queue flags in o_err.
module priority_queue_driver #(
  parameter int QUEUE_DEPTH = 30,
  parameter int DATA_LENGTH = 10,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                               CLK,
  input  logic                               RSTn,
  input  logic                               i_push_valid,
  output logic                               o_push_ready,
  input  logic [DATA_LENGTH-1:0]             i_push_data,
  input  logic                               i_pop_valid,
  output logic                               o_pop_ready,
  output logic                               o_rsp_valid,
  input  logic                               i_rsp_ready,
  output logic [DATA_LENGTH-1:0]             o_rsp_data,
  output logic                               o_pq_write,
  output logic                               o_pq_valid,
  output logic [DATA_LENGTH-1:0]             o_pq_data,
  input  logic                               i_pq_full,
  input  logic                               i_pq_empty,
  input  logic                               i_pq_valid,
  input  logic [DATA_LENGTH-1:0]             i_pq_data,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   o_level,
  output logic                               o_err
);

  localparam int LW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(RSP_DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(RSP_DEPTH - 1);

  typedef enum logic {GNT_PUSH = 1'b0, GNT_POP = 1'b1} grant_e;

  grant_e                 r_last_grant;
  logic                   r_inflight;
  logic                   r_err;
  logic [LW-1:0]          r_level;
  logic [DATA_LENGTH-1:0] r_mem [RSP_DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;

  logic        w_push_ok;
  logic        w_pop_ok;
  logic        w_push_gnt;
  logic        w_pop_gnt;
  logic        w_rsp_wr;
  logic        w_rsp_rd;
  logic        w_chk_err;
  logic [CW:0] w_credit_used;

  // A pop is only issued when its result is guaranteed a FIFO slot; a same-cycle drain is not credited.
  assign w_credit_used = (CW+1)'(r_count) + (CW+1)'(r_inflight);
  assign w_push_ok     = i_push_valid & ~i_pq_full;
  assign w_pop_ok      = i_pop_valid & ~i_pq_empty & (w_credit_used < CREDIT_MAX);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    w_push_gnt = 1'b0;
    w_pop_gnt  = 1'b0;
    if (w_push_ok && w_pop_ok) begin
      if (r_last_grant == GNT_POP) w_push_gnt = 1'b1;
      else                         w_pop_gnt  = 1'b1;
    end else begin
      w_push_gnt = w_push_ok;
      w_pop_gnt  = w_pop_ok;
    end
  end

  assign o_push_ready = w_push_gnt;
  assign o_pop_ready  = w_pop_gnt;
  assign o_pq_valid   = w_push_gnt | w_pop_gnt;
  assign o_pq_write   = w_push_gnt;
  assign o_pq_data    = w_push_gnt ? i_push_data : '0;

  assign w_rsp_wr    = i_pq_valid & r_inflight;
  assign w_rsp_rd    = o_rsp_valid & i_rsp_ready;
  assign o_rsp_valid = (r_count != '0);
  assign o_rsp_data  = r_mem[r_rd_ptr];
  assign o_level     = r_level;
  assign o_err       = r_err;

`ifdef PQ_DRIVER_CHECK_EN
  logic r_gnt_prev;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_gnt_prev <= 1'b0;
    else       r_gnt_prev <= w_push_gnt | w_pop_gnt;
  end

  // The full comparison is skipped right after a grant, while the queue's full flag may still settle.
  assign w_chk_err = ((r_level == '0) != i_pq_empty) |
                     (~r_gnt_prev & ((r_level == LW'(QUEUE_DEPTH)) != i_pq_full));
`else
  assign w_chk_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_last_grant <= GNT_POP;
      r_inflight   <= 1'b0;
      r_level      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_inflight <= w_pop_gnt;
      if (w_push_gnt | w_pop_gnt) r_last_grant <= w_push_gnt ? GNT_PUSH : GNT_POP;
      if (w_push_gnt)     r_level <= r_level + LW'(1);
      else if (w_pop_gnt) r_level <= r_level - LW'(1);
      if ((i_pq_valid & ~r_inflight) | w_chk_err) r_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_rsp_wr) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
      if (w_rsp_rd) r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
      case ({w_rsp_wr, w_rsp_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only read once the count says they were written.
  always_ff @(posedge CLK) begin
    if (w_rsp_wr) r_mem[r_wr_ptr] <= i_pq_data;
  end

endmodule

// File: tb/tb_priority_queue_driver.sv
// Self-checking bench for priority_queue_driver: a behavioural priority queue drives the queue-side
// ports, and a reference model of the driver rules predicts grants, responses, level and error.
module tb_priority_queue_driver;

  localparam int QD = 30;
  localparam int DL = 10;
  localparam int RD = 4;
  localparam int LW = $clog2(QD + 1);

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          i_push_valid;
  logic [DL-1:0] i_push_data;
  logic          i_pop_valid;
  logic          i_rsp_ready;
  logic          o_push_ready;
  logic          o_pop_ready;
  logic          o_rsp_valid;
  logic [DL-1:0] o_rsp_data;
  logic          o_pq_write;
  logic          o_pq_valid;
  logic [DL-1:0] o_pq_data;
  logic          i_pq_full;
  logic          i_pq_empty;
  logic          i_pq_valid;
  logic [DL-1:0] i_pq_data;
  logic [LW-1:0] o_level;
  logic          o_err;

  logic          m_full, m_empty, m_valid;
  logic [DL-1:0] m_data;
  logic          frc_valid, frc_nempty;

  assign i_pq_full  = m_full;
  assign i_pq_empty = m_empty & ~frc_nempty;
  assign i_pq_valid = m_valid | frc_valid;
  assign i_pq_data  = m_data;

  priority_queue_driver #(.QUEUE_DEPTH(QD), .DATA_LENGTH(DL), .RSP_DEPTH(RD)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .i_push_valid(i_push_valid), .o_push_ready(o_push_ready), .i_push_data(i_push_data),
    .i_pop_valid(i_pop_valid), .o_pop_ready(o_pop_ready),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_pq_write(o_pq_write), .o_pq_valid(o_pq_valid), .o_pq_data(o_pq_data),
    .i_pq_full(i_pq_full), .i_pq_empty(i_pq_empty), .i_pq_valid(i_pq_valid), .i_pq_data(i_pq_data),
    .o_level(o_level), .o_err(o_err)
  );

  always #5 CLK = ~CLK;

  // Behavioural priority queue: flags show occupancy after all earlier requests, pop data 1 cycle later.
  logic [DL-1:0] env_q[$];
  always @(posedge CLK or negedge RSTn) begin
    int idx;
    if (!RSTn) begin
      env_q.delete();
      m_valid <= 1'b0;
      m_data  <= '0;
      m_full  <= 1'b0;
      m_empty <= 1'b1;
    end else begin
      m_valid <= 1'b0;
      if (o_pq_valid && o_pq_write) begin
        if (env_q.size() < QD) env_q.push_back(o_pq_data);
      end else if (o_pq_valid && env_q.size() != 0) begin
        idx = 0;
        for (int k = 1; k < env_q.size(); k++) if (env_q[k] < env_q[idx]) idx = k;
        m_valid <= 1'b1;
        m_data  <= env_q[idx];
        env_q.delete(idx);
      end
      m_full  <= (env_q.size() == QD);
      m_empty <= (env_q.size() == 0);
    end
  end

  int errors = 0;
  int checks = 0;

  int            ref_level;
  bit            ref_last_push;
  bit            ref_err;
  logic [DL-1:0] exp_rsp[$];
  bit            pend_valid;
  logic [DL-1:0] pend_data;
  bit            exp_push_gnt, exp_pop_gnt, exp_rsp_valid;
  logic [DL-1:0] exp_rsp_data;

  function automatic logic [DL-1:0] env_min();
    logic [DL-1:0] m;
    m = '1;
    foreach (env_q[k]) if (env_q[k] < m) m = env_q[k];
    return m;
  endfunction

  function automatic void reset_ref();
    ref_level     = 0;
    ref_last_push = 1'b0;
    ref_err       = 1'b0;
    exp_rsp.delete();
    pend_valid    = 1'b0;
    pend_data     = '0;
  endfunction

  // Drive one cycle of inputs (at posedge+1) and predict what the driver must show this cycle.
  task automatic apply(input bit pv, input logic [DL-1:0] pd, input bit popv, input bit rr);
    bit push_ok, pop_ok;
    i_push_valid = pv;
    i_push_data  = pd;
    i_pop_valid  = popv;
    i_rsp_ready  = rr;
    #1;
    push_ok       = pv && (ref_level < QD);
    pop_ok        = popv && (ref_level > 0) && ((exp_rsp.size() + int'(pend_valid)) < RD);
    exp_push_gnt  = push_ok && (!pop_ok || !ref_last_push);
    exp_pop_gnt   = pop_ok && !exp_push_gnt;
    exp_rsp_valid = (exp_rsp.size() != 0);
    exp_rsp_data  = exp_rsp_valid ? exp_rsp[0] : '0;
  endtask

  task automatic tick();
    if (exp_rsp_valid && i_rsp_ready) void'(exp_rsp.pop_front());
    if (pend_valid) exp_rsp.push_back(pend_data);
    if (frc_valid && !pend_valid) ref_err = 1'b1;
    pend_valid = exp_pop_gnt;
    pend_data  = exp_pop_gnt ? env_min() : '0;
    if (exp_push_gnt) ref_level++;
    if (exp_pop_gnt)  ref_level--;
    if (exp_push_gnt || exp_pop_gnt) ref_last_push = exp_push_gnt;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    i_push_valid = 1'b0; i_pop_valid = 1'b0; i_rsp_ready = 1'b0; i_push_data = '0;
    frc_valid = 1'b0; frc_nempty = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b1;
    reset_ref();
  endtask

  task automatic test_reset();
    do_reset();
    apply(1'b0, '0, 1'b0, 1'b1);
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0", o_rsp_valid); end
    checks++; if (o_level !== '0)       begin errors++; $display("FAIL reset_level: got %0d exp 0", o_level); end
    checks++; if (o_err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b exp 0", o_err); end
    checks++; if (o_pq_valid !== 1'b0)  begin errors++; $display("FAIL reset_pq_valid: got %b exp 0", o_pq_valid); end
    apply(1'b1, DL'(7), 1'b1, 1'b1);
    checks++; if ({o_push_ready, o_pop_ready, o_pq_write} !== 3'b101)
      begin errors++; $display("FAIL reset_first_grant: got push/pop/write=%b exp 101", {o_push_ready, o_pop_ready, o_pq_write}); end
    checks++; if (o_pq_data !== DL'(7)) begin errors++; $display("FAIL reset_pq_data: got %0d exp 7", o_pq_data); end
    tick();
  endtask

  task automatic test_basic();
    logic [DL-1:0] want [3];
    logic [DL-1:0] vals [3];
    int k;
    want[0] = DL'(3); want[1] = DL'(5); want[2] = DL'(9);
    vals[0] = DL'(5); vals[1] = DL'(3); vals[2] = DL'(9);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, vals[i], 1'b0, 1'b1);
      tick();
    end
    apply(1'b0, '0, 1'b0, 1'b1);
    checks++; if (o_level !== LW'(3)) begin errors++; $display("FAIL basic_level3: got %0d exp 3", o_level); end
    k = 0;
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, '0, (i < 3), 1'b1);
      if (i < 3) begin
        checks++; if (o_pop_ready !== 1'b1) begin errors++; $display("FAIL basic_pop_ready[%0d]: got %b exp 1", i, o_pop_ready); end
      end
      if (o_rsp_valid === 1'b1 && k < 3) begin
        checks++; if (o_rsp_data !== want[k]) begin errors++; $display("FAIL basic_rsp[%0d]: got %0d exp %0d", k, o_rsp_data, want[k]); end
        k++;
      end
      tick();
    end
    checks++; if (k != 3) begin errors++; $display("FAIL basic_rsp_count: got %0d exp 3", k); end
    checks++; if (o_level !== '0) begin errors++; $display("FAIL basic_level0: got %0d exp 0", o_level); end
  endtask

  task automatic test_full();
    int gnt;
    do_reset();
    gnt = 0;
    for (int i = 0; i < QD; i++) begin
      apply(1'b1, DL'($urandom), 1'b0, 1'b1);
      if (o_push_ready === 1'b1) gnt++;
      tick();
    end
    checks++; if (gnt != QD) begin errors++; $display("FAIL full_fill_grants: got %0d exp %0d", gnt, QD); end
    apply(1'b1, DL'($urandom), 1'b0, 1'b1);
    checks++; if (o_level !== LW'(QD)) begin errors++; $display("FAIL full_level: got %0d exp %0d", o_level, QD); end
    checks++; if (o_push_ready !== 1'b0) begin errors++; $display("FAIL full_push_blocked: got %b exp 0", o_push_ready); end
    tick();
    apply(1'b1, DL'($urandom), 1'b1, 1'b1);
    checks++; if ({o_push_ready, o_pop_ready} !== 2'b01)
      begin errors++; $display("FAIL full_pop_grant: got push/pop=%b exp 01", {o_push_ready, o_pop_ready}); end
    tick();
    apply(1'b1, DL'($urandom), 1'b0, 1'b1);
    checks++; if (o_push_ready !== 1'b1) begin errors++; $display("FAIL full_push_resume: got %b exp 1", o_push_ready); end
    tick();
    apply(1'b0, '0, 1'b0, 1'b1);
    checks++; if (o_level !== LW'(QD)) begin errors++; $display("FAIL full_level_after: got %0d exp %0d", o_level, QD); end
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_data !== exp_rsp_data)
      begin errors++; $display("FAIL full_rsp: got v=%b d=%0d exp v=1 d=%0d", o_rsp_valid, o_rsp_data, exp_rsp_data); end
    tick();
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, DL'($urandom), 1'b0, 1'b1);
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      apply(1'b1, DL'($urandom), 1'b1, 1'b1);
      checks++;
      if ({o_push_ready, o_pop_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        begin errors++; $display("FAIL alt_grant[%0d]: got push/pop=%b", i, {o_push_ready, o_pop_ready}); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int gnt, taken;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, DL'($urandom), 1'b0, 1'b1);
      tick();
    end
    gnt = 0;
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, '0, 1'b1, 1'b0);
      if (o_pop_ready === 1'b1) gnt++;
      if (i == 5) begin
        checks++; if (o_pop_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_blocked: got %b exp 0", o_pop_ready); end
      end
      tick();
    end
    checks++; if (gnt != RD) begin errors++; $display("FAIL bp_grants: got %0d exp %0d", gnt, RD); end
    taken = 0;
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, '0, 1'b1, 1'b1);
      if (o_pop_ready === 1'b1) gnt++;
      checks++; if (o_rsp_valid !== exp_rsp_valid)
        begin errors++; $display("FAIL bp_rsp_valid[%0d]: got %b exp %b", i, o_rsp_valid, exp_rsp_valid); end
      if (exp_rsp_valid) begin
        taken++;
        checks++; if (o_rsp_data !== exp_rsp_data)
          begin errors++; $display("FAIL bp_rsp_data[%0d]: got %0d exp %0d", i, o_rsp_data, exp_rsp_data); end
      end
      tick();
    end
    checks++; if (gnt != 8)   begin errors++; $display("FAIL bp_total_grants: got %0d exp 8", gnt); end
    checks++; if (taken != 8) begin errors++; $display("FAIL bp_drained: got %0d exp 8", taken); end
    checks++; if (o_level !== '0) begin errors++; $display("FAIL bp_level: got %0d exp 0", o_level); end
  endtask

  task automatic test_random();
    bit pv, popv, rr;
    logic [DL-1:0] pd;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      case (i / 200)
        0:       begin pv = ($urandom % 4) != 0; popv = ($urandom % 4) == 0; end
        1:       begin pv = $urandom % 2;        popv = $urandom % 2;        end
        default: begin pv = ($urandom % 4) == 0; popv = ($urandom % 4) != 0; end
      endcase
      rr = ($urandom % 4) != 0;
      pd = DL'($urandom);
      apply(pv, pd, popv, rr);
      checks++; if (o_push_ready !== exp_push_gnt)
        begin errors++; $display("FAIL rnd_push_ready[%0d]: got %b exp %b", i, o_push_ready, exp_push_gnt); end
      checks++; if (o_pop_ready !== exp_pop_gnt)
        begin errors++; $display("FAIL rnd_pop_ready[%0d]: got %b exp %b", i, o_pop_ready, exp_pop_gnt); end
      checks++; if ({o_pq_valid, o_pq_write} !== {exp_push_gnt | exp_pop_gnt, exp_push_gnt})
        begin errors++; $display("FAIL rnd_pq_req[%0d]: got valid/write=%b%b", i, o_pq_valid, o_pq_write); end
      checks++; if (o_pq_data !== (exp_push_gnt ? pd : '0))
        begin errors++; $display("FAIL rnd_pq_data[%0d]: got %0d exp %0d", i, o_pq_data, exp_push_gnt ? pd : '0); end
      checks++; if (o_rsp_valid !== exp_rsp_valid)
        begin errors++; $display("FAIL rnd_rsp_valid[%0d]: got %b exp %b", i, o_rsp_valid, exp_rsp_valid); end
      if (exp_rsp_valid) begin
        checks++; if (o_rsp_data !== exp_rsp_data)
          begin errors++; $display("FAIL rnd_rsp_data[%0d]: got %0d exp %0d", i, o_rsp_data, exp_rsp_data); end
      end
      checks++; if (o_level !== LW'(ref_level))
        begin errors++; $display("FAIL rnd_level[%0d]: got %0d exp %0d", i, o_level, ref_level); end
      checks++; if (o_err !== ref_err)
        begin errors++; $display("FAIL rnd_err[%0d]: got %b exp %b", i, o_err, ref_err); end
      tick();
    end
  endtask

  task automatic test_error();
    do_reset();
    apply(1'b0, '0, 1'b1, 1'b1);
    checks++; if ({o_pop_ready, o_pq_valid} !== 2'b00)
      begin errors++; $display("FAIL err_empty_pop: got pop_ready/pq_valid=%b exp 00", {o_pop_ready, o_pq_valid}); end
    tick();
    frc_valid = 1'b1;
    apply(1'b0, '0, 1'b0, 1'b1);
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_before: got %b exp 0", o_err); end
    tick();
    frc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, '0, 1'b0, 1'b1);
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky[%0d]: got %b exp 1", i, o_err); end
      checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL err_dropped[%0d]: got %b exp 0", i, o_rsp_valid); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, DL'($urandom), 1'b0, 1'b1);
      tick();
    end
    apply(1'b0, '0, 1'b1, 1'b1);
    checks++; if (o_pop_ready !== 1'b1) begin errors++; $display("FAIL rstmid_pop_grant: got %b exp 1", o_pop_ready); end
    tick();
    RSTn = 1'b0;
    i_pop_valid = 1'b0;
    #1;
    checks++; if ({o_rsp_valid, o_err} !== 2'b00)
      begin errors++; $display("FAIL rstmid_async: got rsp_valid/err=%b exp 00", {o_rsp_valid, o_err}); end
    checks++; if (o_level !== '0) begin errors++; $display("FAIL rstmid_level: got %0d exp 0", o_level); end
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    reset_ref();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, '0, 1'b0, 1'b1);
      checks++; if ({o_rsp_valid, o_err, o_level} !== '0)
        begin errors++; $display("FAIL rstmid_after[%0d]: got rsp_valid=%b err=%b level=%0d", i, o_rsp_valid, o_err, o_level); end
      tick();
    end
`ifdef PQ_DRIVER_CHECK_EN
    frc_nempty = 1'b1;
    apply(1'b0, '0, 1'b0, 1'b1);
    tick();
    frc_nempty = 1'b0;
    apply(1'b0, '0, 1'b0, 1'b1);
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL chk_empty_mismatch: got %b exp 1", o_err); end
    tick();
`endif
  endtask

  initial begin
    RSTn = 1'b0;
    i_push_valid = 1'b0; i_pop_valid = 1'b0; i_rsp_ready = 1'b0; i_push_data = '0;
    frc_valid = 1'b0; frc_nempty = 1'b0;
    reset_ref();
    test_reset();
    test_basic();
    test_full();
    test_alternate();
    test_backpressure();
    test_random();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
